ddram_ch_arbiter: RTL
=====================

Name: ddram_ch_arbiter

Overview:
- Shares one `ddram` request channel (`req`/`rnw`/`addr`/`din` → `ready`/`dout` pulse protocol) between three GBA-side requesters, e.g. cart ROM prefetch, DMA and backup-save access.
- Latches pulse requests, grants round-robin and issues one downstream transaction at a time.
- Routes the completion pulse and read data back to the granted client only.
- Sits between the core memory clients and one `chN` port of `ddram`, in the `DDRAM_CLK` domain.

Parameters:
- `AW`, 27, address width; addresses are halfword-indexed, ports `[AW:1]`.
- `DW`, 32, data width for client and memory data.
- `TIMEOUT`, 1023, WAIT-state cycle limit (used only with the optional feature).

Ports:
- `DDRAM_CLK`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `c0_addr`, `c1_addr`, `c2_addr`  in  `AW`  client address.
- `c0_din`, `c1_din`, `c2_din`  in  `DW`  client write data.
- `c0_rnw`, `c1_rnw`, `c2_rnw`  in  1  1 = read, 0 = write.
- `c0_req`, `c1_req`, `c2_req`  in  1  one-cycle request pulse; `addr`/`din`/`rnw` held stable until the matching `ready`.
- `c0_dout`, `c1_dout`, `c2_dout`  out  `DW`  read data, registered, held until that client's next completion.
- `c0_ready`, `c1_ready`, `c2_ready`  out  1  one-cycle completion pulse.
- `mem_addr`  out  `AW`  to `ddram` `chN_addr`.
- `mem_din`  out  `DW`  to `ddram` `chN_din`.
- `mem_rnw`  out  1  to `ddram` `chN_rnw`.
- `mem_req`  out  1  one-cycle pulse to `ddram` `chN_req`.
- `mem_dout`  in  `DW`  from `ddram` `chN_dout`.
- `mem_ready`  in  1  completion pulse from `ddram` (reads and writes).
- `overrun`  out  1  sticky: a client pulsed `req` while it already had a pending request.
- `timeout`  out  1  sticky timeout flag (optional feature; constant 0 without it).

Behaviour:
- Reset (asynchronous):
  - `state` = IDLE, `pend` = 0, round-robin pointer `last` = 2, so client 0 has first priority.
  - Output reset values: `mem_req` = 0, `mem_addr` = 0, `mem_din` = 0, `mem_rnw` = 1, all `cN_ready` = 0, all `cN_dout` = 0, `overrun` = 0, `timeout` = 0.
- Pending latch:
  - `pend[n]` is set by `cN_req` and cleared when client n is granted.
  - A `req` arriving in the same cycle as that client's grant is consumed by the grant, not re-queued.
- `elig` = `pend` | `req` (combinational), so a request is eligible in the cycle it arrives.
- States are IDLE and WAIT (encoded as two bits).
- IDLE:
  - If `elig` ≠ 0, grant the first eligible client searching `last`+1, `last`+2, `last`+3 (mod 3).
  - Register `owner`; copy that client's `addr`/`din`/`rnw` to the `mem_*` outputs.
  - Set `mem_req` = 1 for exactly the next cycle; `last` = `owner`; go to WAIT.
  - `mem_ready` is ignored in IDLE.
- WAIT:
  - `mem_req` = 0 and `mem_*` outputs are held.
  - On `mem_ready`:
    - If the transaction was a read, `c[owner]_dout` <= `mem_dout`; write completions leave `dout` unchanged.
    - `c[owner]_ready` = 1 for the next cycle only; go to IDLE.
- Latency:
  - Client `req` in cycle 0 with the arbiter idle → `mem_req` high in cycle 1.
  - `mem_ready` in cycle k → `cN_ready` and valid `dout` in cycle k+1.
  - The earliest next `mem_req` is cycle k+2; back-to-back grants are never closer than 2 cycles.
- Fairness: with all three pending continuously, grant order is strictly 0,1,2,0,1,2…
- Overrun:
  - A `req` pulse from client n while `pend[n]` = 1 is merged and sets `overrun`.
  - A `req` from the current owner while in WAIT is legal: it sets `pend` and is serviced later.
- Reset mid-transaction:
  - Any in-flight transaction is dropped and no `ready` is produced for it.
  - A stale `mem_ready` arriving after reset is ignored (state is IDLE).
- Clients never see `ready` without a preceding grant; at most one `cN_ready` is high in any cycle.

Optional Feature:
- Macro `DDRAM_ARB_TIMEOUT_EN`.
- Defined:
  - A 10+ bit counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without `mem_ready`: pulse `c[owner]_ready`, set `c[owner]_dout` = all ones for reads, set `timeout`, go to IDLE.
  - A late `mem_ready` then arrives in IDLE and is ignored.
- Not defined: no counter; WAIT lasts indefinitely; `timeout` is tied 0.

Test Plan:
- Reset, then `c0_req` read at `addr` 0x100 → `mem_req` 1 cycle later with `mem_addr` = 0x100, `mem_rnw` = 1; model returns 0xDEADBEEF 5 cycles later → `c0_ready` pulse, `c0_dout` = 0xDEADBEEF; `c1_dout`/`c2_dout` stay 0.
- `c0`, `c1`, `c2` `req` in the same cycle, model latency 3 → `mem_req` order 0,1,2; each `cN_ready` exactly once; `mem_req` pulses spaced ≥ 5 cycles apart.
- All clients re-request immediately on `ready` for 30 grants → grant sequence repeats 0,1,2; no client is granted twice in a row.
- `c2` write `din` = 0x12345678 → `mem_rnw` = 0, `mem_din` = 0x12345678; `c2_ready` pulses; `c2_dout` unchanged.
- `c1_req` pulsed twice while its first request is still pending (not yet granted) → `overrun` = 1, only one `c1` transaction issued.
- Assert `reset` during WAIT, then deliver `mem_ready` → no `cN_ready`; all outputs at reset values; with `DDRAM_ARB_TIMEOUT_EN` and `TIMEOUT` = 16, no `mem_ready` → `c0_ready` after 16 WAIT cycles, `c0_dout` = 0xFFFFFFFF, `timeout` = 1.

Source files
------------

// File: rtl/ddram_ch_arbiter.sv
// Three-client round-robin arbiter in front of one ddram request channel (req/ready pulse protocol).
// Optional WAIT-state watchdog enabled by defining DDRAM_ARB_TIMEOUT_EN.
module ddram_ch_arbiter #(
    parameter int AW      = 27,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic          DDRAM_CLK,
    input  logic          reset,
    input  logic [AW:1]   c0_addr,
    input  logic [AW:1]   c1_addr,
    input  logic [AW:1]   c2_addr,
    input  logic [DW-1:0] c0_din,
    input  logic [DW-1:0] c1_din,
    input  logic [DW-1:0] c2_din,
    input  logic          c0_rnw,
    input  logic          c1_rnw,
    input  logic          c2_rnw,
    input  logic          c0_req,
    input  logic          c1_req,
    input  logic          c2_req,
    output logic [DW-1:0] c0_dout,
    output logic [DW-1:0] c1_dout,
    output logic [DW-1:0] c2_dout,
    output logic          c0_ready,
    output logic          c1_ready,
    output logic          c2_ready,
    output logic [AW:1]   mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_rnw,
    output logic          mem_req,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_ready,
    output logic          overrun,
    output logic          timeout
);

    // state | meaning
    // IDLE  | arbitrate over pending and newly arriving requests
    // WAIT  | one transaction issued, waiting for mem_ready
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01
    } state_t;

    localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    state_t        r_state;
    logic [2:0]    r_pend;
    logic [1:0]    r_last;
    logic [1:0]    r_owner;
    logic [2:0]    r_ready;
    logic [DW-1:0] r_dout [3];
    logic [AW:1]   r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic          r_mem_rnw;
    logic          r_mem_req;
    logic          r_overrun;

    logic [2:0]    w_req;
    logic [2:0]    w_elig;
    logic [2:0]    w_gnt;
    logic          w_any;
    logic [1:0]    w_sel;
    logic [1:0]    w_c1;
    logic [1:0]    w_c2;
    logic [1:0]    w_c3;
    logic [AW:1]   w_addr;
    logic [DW-1:0] w_din;
    logic          w_rnw;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign w_req  = {c2_req, c1_req, c0_req};
    assign w_elig = r_pend | w_req;
    assign w_any  = |w_elig;
    assign w_c1   = nxt(r_last);
    assign w_c2   = nxt(w_c1);
    assign w_c3   = nxt(w_c2);

    always_comb begin
        w_sel = w_c3;
        if (w_elig[w_c1])
            w_sel = w_c1;
        else if (w_elig[w_c2])
            w_sel = w_c2;
        w_gnt = w_any ? (3'b001 << w_sel) : 3'b000;
    end

    always_comb begin
        w_addr = c0_addr;
        w_din  = c0_din;
        w_rnw  = c0_rnw;
        case (w_sel)
            2'd1: begin
                w_addr = c1_addr;
                w_din  = c1_din;
                w_rnw  = c1_rnw;
            end
            2'd2: begin
                w_addr = c2_addr;
                w_din  = c2_din;
                w_rnw  = c2_rnw;
            end
            default: ;
        endcase
    end

`ifdef DDRAM_ARB_TIMEOUT_EN
    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout;
    logic          w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt + TW'(1)) == TW'(TIMEOUT);
    assign timeout   = r_timeout;
`else
    logic [TW-1:0] w_unused_tmo;

    assign w_unused_tmo = TW'(TIMEOUT);
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pend     <= 3'b000;
            r_last     <= 2'd2;
            r_owner    <= 2'd0;
            r_ready    <= 3'b000;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_rnw  <= 1'b1;
            r_mem_req  <= 1'b0;
            r_overrun  <= 1'b0;
            for (int n = 0; n < 3; n++)
                r_dout[n] <= '0;
`ifdef DDRAM_ARB_TIMEOUT_EN
            r_tmo_cnt  <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_ready   <= 3'b000;
            r_mem_req <= 1'b0;
            r_overrun <= r_overrun | (|(w_req & r_pend));
            case (r_state)
                IDLE: begin
                    // a request arriving with its own grant is consumed, not re-queued
                    r_pend <= w_elig & ~w_gnt;
                    if (w_any) begin
                        r_owner    <= w_sel;
                        r_last     <= w_sel;
                        r_mem_addr <= w_addr;
                        r_mem_din  <= w_din;
                        r_mem_rnw  <= w_rnw;
                        r_mem_req  <= 1'b1;
                        r_state    <= WAIT;
`ifdef DDRAM_ARB_TIMEOUT_EN
                        r_tmo_cnt  <= '0;
`endif
                    end
                end
                WAIT: begin
                    r_pend <= w_elig;
                    if (mem_ready) begin
                        for (int n = 0; n < 3; n++)
                            if (r_mem_rnw && r_owner == 2'(n))
                                r_dout[n] <= mem_dout;
                        r_ready <= 3'b001 << r_owner;
                        r_state <= IDLE;
                    end
`ifdef DDRAM_ARB_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        for (int n = 0; n < 3; n++)
                            if (r_mem_rnw && r_owner == 2'(n))
                                r_dout[n] <= '1;
                        r_ready   <= 3'b001 << r_owner;
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign c0_dout  = r_dout[0];
    assign c1_dout  = r_dout[1];
    assign c2_dout  = r_dout[2];
    assign c0_ready = r_ready[0];
    assign c1_ready = r_ready[1];
    assign c2_ready = r_ready[2];
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_rnw  = r_mem_rnw;
    assign mem_req  = r_mem_req;
    assign overrun  = r_overrun;

endmodule
